// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both CDBs
// for operand wakeup, and issues the lowest-index ready op as a registered packet.
module alu_reservation_station #(
    parameter int RS_SIZE    = 8,
    parameter int RS_WIDTH   = 3,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  valid_dsp_in,
    input  logic [ADDR_WIDTH-1:0] pc_dsp_in,
    input  logic [OP_WIDTH-1:0]   opcode_dsp_in,
    input  logic                  qj_busy_dsp_in,
    input  logic                  qk_busy_dsp_in,
    input  logic [ROB_WIDTH-1:0]  qj_dsp_in,
    input  logic [ROB_WIDTH-1:0]  qk_dsp_in,
    input  logic [DATA_WIDTH-1:0] vj_dsp_in,
    input  logic [DATA_WIDTH-1:0] vk_dsp_in,
    input  logic [DATA_WIDTH-1:0] imm_dsp_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_dsp_in,
    output logic                  full_dsp_out,
    input  logic                  rdy_a_cdb_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_a_cdb_in,
    input  logic [DATA_WIDTH-1:0] result_a_cdb_in,
    input  logic                  rdy_l_cdb_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_l_cdb_in,
    input  logic [DATA_WIDTH-1:0] result_l_cdb_in,
    input  logic                  idle_alu_in,
    output logic                  rdy_alu_out,
    output logic [ADDR_WIDTH-1:0] pc_alu_out,
    output logic [OP_WIDTH-1:0]   opcode_alu_out,
    output logic [DATA_WIDTH-1:0] vj_alu_out,
    output logic [DATA_WIDTH-1:0] vk_alu_out,
    output logic [DATA_WIDTH-1:0] imm_alu_out,
    output logic [ROB_WIDTH-1:0]  rob_id_alu_out
);

    logic [RS_SIZE-1:0]    busy, qj_busy, qk_busy;
    logic [ADDR_WIDTH-1:0] pc     [RS_SIZE];
    logic [OP_WIDTH-1:0]   opcode [RS_SIZE];
    logic [DATA_WIDTH-1:0] vj     [RS_SIZE];
    logic [DATA_WIDTH-1:0] vk     [RS_SIZE];
    logic [DATA_WIDTH-1:0] imm    [RS_SIZE];
    logic [ROB_WIDTH-1:0]  qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  qk     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  rob_id [RS_SIZE];

    logic [DATA_WIDTH-1:0] vj_nxt [RS_SIZE];
    logic [DATA_WIDTH-1:0] vk_nxt [RS_SIZE];
    logic [RS_SIZE-1:0]    qj_busy_nxt, qk_busy_nxt;
    logic [DATA_WIDTH-1:0] dj_val, dk_val;
    logic                  dj_busy, dk_busy;
    logic [RS_WIDTH-1:0]   free_idx, issue_idx;
    logic                  has_ready, dsp_en, issue_en;

    // Resolve one operand against both CDBs; ALU CDB wins on a (illegal) double match.
    function automatic logic [DATA_WIDTH:0] snoop(
        input logic                  q_busy,
        input logic [ROB_WIDTH-1:0]  q,
        input logic [DATA_WIDTH-1:0] v,
        input logic                  a_vld,
        input logic [ROB_WIDTH-1:0]  a_tag,
        input logic [DATA_WIDTH-1:0] a_val,
        input logic                  l_vld,
        input logic [ROB_WIDTH-1:0]  l_tag,
        input logic [DATA_WIDTH-1:0] l_val
    );
        if (q_busy && a_vld && q == a_tag) return {1'b0, a_val};
        if (q_busy && l_vld && q == l_tag) return {1'b0, l_val};
        return {q_busy, v};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {qj_busy_nxt[i], vj_nxt[i]} = snoop(qj_busy[i], qj[i], vj[i],
                rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
            {qk_busy_nxt[i], vk_nxt[i]} = snoop(qk_busy[i], qk[i], vk[i],
                rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
        end
        {dj_busy, dj_val} = snoop(qj_busy_dsp_in, qj_dsp_in, vj_dsp_in,
            rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
            rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
        {dk_busy, dk_val} = snoop(qk_busy_dsp_in, qk_dsp_in, vk_dsp_in,
            rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
            rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
    end

    // Priority encoders scan downward so the lowest index is the last assignment.
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        has_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = RS_WIDTH'(i);
            if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
                issue_idx = RS_WIDTH'(i);
                has_ready = 1'b1;
            end
        end
    end

    assign full_dsp_out = &busy;
    assign dsp_en       = valid_dsp_in && !full_dsp_out;
    assign issue_en     = idle_alu_in && has_ready;

    // Stage boundary: entry control state and the registered issue packet.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            qj_busy        <= '0;
            qk_busy        <= '0;
            rdy_alu_out    <= 1'b0;
            pc_alu_out     <= '0;
            opcode_alu_out <= '0;
            vj_alu_out     <= '0;
            vk_alu_out     <= '0;
            imm_alu_out    <= '0;
            rob_id_alu_out <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy        <= '0;
                rdy_alu_out <= 1'b0;
            end else begin
                qj_busy     <= qj_busy_nxt;
                qk_busy     <= qk_busy_nxt;
                rdy_alu_out <= issue_en;
                if (issue_en) begin
                    busy[issue_idx] <= 1'b0;
                    pc_alu_out      <= pc[issue_idx];
                    opcode_alu_out  <= opcode[issue_idx];
                    vj_alu_out      <= vj[issue_idx];
                    vk_alu_out      <= vk[issue_idx];
                    imm_alu_out     <= imm[issue_idx];
                    rob_id_alu_out  <= rob_id[issue_idx];
                end
                if (dsp_en) begin
                    busy[free_idx]    <= 1'b1;
                    qj_busy[free_idx] <= dj_busy;
                    qk_busy[free_idx] <= dk_busy;
                end
            end
        end else begin
            rdy_alu_out <= 1'b0;
        end
    end

    // Stage boundary: entry payload; meaningless while the entry is not busy.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                vj[i] <= vj_nxt[i];
                vk[i] <= vk_nxt[i];
            end
            if (dsp_en) begin
                pc[free_idx]     <= pc_dsp_in;
                opcode[free_idx] <= opcode_dsp_in;
                vj[free_idx]     <= dj_val;
                vk[free_idx]     <= dk_val;
                imm[free_idx]    <= imm_dsp_in;
                qj[free_idx]     <= qj_dsp_in;
                qk[free_idx]     <= qk_dsp_in;
                rob_id[free_idx] <= rob_id_dsp_in;
            end
        end
    end

endmodule
